ram_cmd_ctrl: RTL and testbench

Parametrised command-driven RAM controller behind the SPI slave front end. It accepts framed words (2-bit opcode plus DATA_W payload) on an rx_valid strobe and keeps independent write and read address pointers, with optional auto-increment. Writes go into an internal synchronous single-port memory. Read data is returned on dout and held until the downstream serialiser acknowledges it with tx_ready. Protocol errors are reported on a one-cycle err pulse.

---
 rtl/ram_cmd_pkg.sv | 39 +++
 rtl/ram_cmd_ctrl_ram.sv | 35 +++
 rtl/ram_cmd_ctrl.sv | 133 +++++++++++++
 tb/tb_ram_cmd_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_cmd_pkg.sv
// Shared opcode, FSM-state and decoded-command definitions
// for the SPI-side RAM command controller.
package ram_cmd_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        TX    = 2'b10
    } state_t;

    typedef struct packed {
        logic wr_addr;
        logic wr_data;
        logic rd_addr;
        logic rd_data;
    } cmd_t;

    // One-hot decode of an accepted command; all-zero when rx_valid is low.
    function automatic cmd_t decode(input logic vld, input logic [1:0] op);
        cmd_t c;
        c = '0;
        if (vld) begin
            unique case (1'b1)
                (op == OP_WR_ADDR): c.wr_addr = 1'b1;
                (op == OP_WR_DATA): c.wr_data = 1'b1;
                (op == OP_RD_ADDR): c.rd_addr = 1'b1;
                (op == OP_RD_DATA): c.rd_data = 1'b1;
                default:            c = '0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/ram_cmd_ctrl_ram.sv
// Synchronous single-port RAM with a registered read port that only
// updates on a read, so it doubles as the output hold register.
module ram_sp_sync #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] q
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= din;
        end
    end

    // Only the read register is reset; the array keeps its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en && !we) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_cmd_ctrl.sv
// Command decoder, address pointers, read FSM and error pulse
// in front of a single-port synchronous RAM.
module ram_cmd_ctrl
    import ram_cmd_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int AUTO_INC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              err
);

    localparam logic [ADDR_W-1:0] PTR_STEP =
        (AUTO_INC != 0) ? ADDR_W'(1) : '0;

    logic [1:0]        opcode;
    logic [DATA_W-1:0] payload;
    cmd_t              cmd;

    state_t            state;
    state_t            state_nxt;
    logic              rd_fire;
    logic              err_nxt;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;

    assign opcode  = din[DATA_W+1:DATA_W];
    assign payload = din[DATA_W-1:0];
    assign cmd     = decode(rx_valid, opcode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The tx_ready handshake is honoured even on cycles without a command.
    always_comb begin
        state_nxt = state;
        rd_fire   = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd.rd_addr) begin
                    state_nxt = ARMED;
                end else if (cmd.rd_data) begin
                    err_nxt = 1'b1;
                end
            end
            ARMED: begin
                if (cmd.rd_data) begin
                    rd_fire   = 1'b1;
                    state_nxt = TX;
                end
            end
            TX: begin
                if (cmd.rd_data) begin
                    if (tx_ready) begin
                        rd_fire = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (tx_ready) begin
                    state_nxt = ARMED;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (cmd.wr_addr) begin
            wr_ptr <= payload[ADDR_W-1:0];
        end else if (cmd.wr_data) begin
            wr_ptr <= wr_ptr + PTR_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (cmd.rd_addr) begin
            rd_ptr <= payload[ADDR_W-1:0];
        end else if (rd_fire) begin
            rd_ptr <= rd_ptr + PTR_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= err_nxt;
        end
    end

    assign tx_valid = (state == TX);

    // A cycle carries at most one command, so one port serves both pointers.
    assign ram_en   = cmd.wr_data | rd_fire;
    assign ram_addr = cmd.wr_data ? wr_ptr : rd_ptr;

    ram_sp_sync #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ram_en),
        .we    (cmd.wr_data),
        .addr  (ram_addr),
        .din   (payload),
        .q     (dout)
    );

endmodule

// File: tb/tb_ram_cmd_ctrl.sv
// Scoreboard bench: two controllers (auto-increment on and off) share
// stimulus and are compared against a per-cycle behavioural model.
module tb_ram_cmd_ctrl;
    import ram_cmd_pkg::*;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int N  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW+1:0] din = '0;
    logic          rx_valid = 1'b0;
    logic          tx_ready = 1'b0;
    logic [DW-1:0] dout [N];
    logic          tx_valid [N];
    logic          err [N];

    int nvec = 0;
    int nerr = 0;

    ram_cmd_ctrl #(.DATA_W(DW), .ADDR_W(AW), .AUTO_INC(1)) u_inc (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .tx_ready (tx_ready),
        .dout     (dout[0]),
        .tx_valid (tx_valid[0]),
        .err      (err[0])
    );

    ram_cmd_ctrl #(.DATA_W(DW), .ADDR_W(AW), .AUTO_INC(0)) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .tx_ready (tx_ready),
        .dout     (dout[1]),
        .tx_valid (tx_valid[1]),
        .err      (err[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tv;
        logic [7:0] d;
        bit         dk;
        logic       e;
    } exp_t;

    exp_t sbq0 [$];
    exp_t sbq1 [$];

    // Reference model: memory image, pointers, "read address seen" and
    // "word outstanding" flags per instance.
    logic [7:0] m_mem   [N][256];
    bit         m_known [N][256];
    logic [7:0] m_wp    [N];
    logic [7:0] m_rp    [N];
    logic [7:0] m_dout  [N];
    bit         m_dk    [N];
    bit         m_armed [N];
    bit         m_tv    [N];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_wp[i]    = '0;
            m_rp[i]    = '0;
            m_dout[i]  = '0;
            m_dk[i]    = 1'b1;
            m_armed[i] = 1'b0;
            m_tv[i]    = 1'b0;
        end
    endtask

    task automatic model_edge(input bit rv, input logic [1:0] op,
                              input logic [7:0] pl, input bit txr);
        for (int i = 0; i < N; i++) begin
            bit   ai;
            bit   e;
            bit   load;
            bit   drained;
            exp_t x;
            ai      = (i == 0);
            e       = 1'b0;
            load    = 1'b0;
            drained = m_tv[i] && txr;
            if (rv) begin
                case (op)
                    OP_WR_ADDR: m_wp[i] = pl;
                    OP_WR_DATA: begin
                        m_mem[i][m_wp[i]]   = pl;
                        m_known[i][m_wp[i]] = 1'b1;
                        if (ai) m_wp[i] = m_wp[i] + 8'd1;
                    end
                    OP_RD_ADDR: begin
                        m_rp[i]    = pl;
                        m_armed[i] = 1'b1;
                    end
                    default: begin
                        if (!m_armed[i]) begin
                            e = 1'b1;
                        end else if (m_tv[i] && !txr) begin
                            e = 1'b1;
                        end else begin
                            m_dout[i] = m_mem[i][m_rp[i]];
                            m_dk[i]   = m_known[i][m_rp[i]];
                            load      = 1'b1;
                            if (ai) m_rp[i] = m_rp[i] + 8'd1;
                        end
                    end
                endcase
            end
            if (load) m_tv[i] = 1'b1;
            else if (drained) m_tv[i] = 1'b0;
            x.tv = m_tv[i];
            x.d  = m_dout[i];
            x.dk = m_dk[i];
            x.e  = e;
            if (i == 0) sbq0.push_back(x);
            else sbq1.push_back(x);
        end
    endtask

    task automatic mon_check(input int i, input exp_t x);
        chk($sformatf("u%0d.tx_valid", i), tx_valid[i], x.tv);
        chk($sformatf("u%0d.err", i), err[i], x.e);
        if (x.tv && x.dk) begin
            chk($sformatf("u%0d.dout", i), dout[i], x.d);
        end
    endtask

    always @(negedge clk) begin
        if (sbq0.size() != 0) mon_check(0, sbq0.pop_front());
        if (sbq1.size() != 0) mon_check(1, sbq1.pop_front());
    end

    task automatic step(input bit rv, input logic [1:0] op,
                        input logic [7:0] pl, input bit txr);
        rx_valid = rv;
        din      = {op, pl};
        tx_ready = txr;
        @(posedge clk);
        model_edge(rv, op, pl, txr);
        #1;
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s u%0d.tx_valid", tag, i), tx_valid[i], 0);
            chk($sformatf("%s u%0d.dout", tag, i), dout[i], 0);
            chk($sformatf("%s u%0d.err", tag, i), err[i], 0);
        end
        model_reset();
        sbq0.delete();
        sbq1.delete();
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [7:0] wrap_inc [3];
    logic [7:0] rd_pl;

    initial begin
        wrap_inc[0] = 8'h11;
        wrap_inc[1] = 8'h22;
        wrap_inc[2] = 8'h33;
        model_reset();
        do_reset("reset");

        // Basic write then read.
        step(1, OP_WR_ADDR, 8'h10, 0);
        step(1, OP_WR_DATA, 8'hA5, 0);
        step(1, OP_RD_ADDR, 8'h10, 0);
        step(1, OP_RD_DATA, 8'h00, 1);
        @(negedge clk);
        chk("basic dout", dout[0], 8'hA5);
        step(0, OP_WR_ADDR, 8'h00, 1);

        // Pointer wrap with and without auto-increment.
        step(1, OP_WR_ADDR, 8'hFE, 0);
        step(1, OP_WR_DATA, 8'h11, 0);
        step(1, OP_WR_DATA, 8'h22, 0);
        step(1, OP_WR_DATA, 8'h33, 0);
        step(1, OP_RD_ADDR, 8'hFE, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, OP_RD_DATA, 8'h00, 1);
            @(negedge clk);
            chk($sformatf("wrap inc rd%0d", k), dout[0], wrap_inc[k]);
            chk($sformatf("wrap hold rd%0d", k), dout[1], 8'h33);
        end
        step(0, OP_WR_ADDR, 8'h00, 1);

        // Read before any read address is an error.
        do_reset("reset2");
        step(1, OP_RD_DATA, 8'h00, 0);
        @(negedge clk);
        chk("idle rd err", err[0], 1);
        chk("idle rd tx_valid", tx_valid[0], 0);
        step(1, OP_RD_ADDR, 8'h00, 0);
        step(1, OP_RD_DATA, 8'h00, 1);
        @(negedge clk);
        chk("post-err rd", dout[0], 8'h33);
        step(0, OP_WR_ADDR, 8'h00, 1);

        // Overrun while stalled, then back-to-back on the ready edge.
        step(1, OP_WR_ADDR, 8'h20, 0);
        step(1, OP_WR_DATA, 8'h5A, 0);
        step(1, OP_WR_DATA, 8'h6B, 0);
        step(1, OP_WR_DATA, 8'h7C, 0);
        step(1, OP_RD_ADDR, 8'h20, 0);
        step(1, OP_RD_DATA, 8'h00, 0);
        step(0, OP_RD_DATA, 8'h00, 0);
        step(1, OP_RD_DATA, 8'h00, 0);
        @(negedge clk);
        chk("overrun err", err[0], 1);
        chk("overrun dout", dout[0], 8'h5A);
        step(0, OP_RD_DATA, 8'h00, 0);
        step(1, OP_RD_DATA, 8'h00, 1);
        @(negedge clk);
        chk("b2b dout", dout[0], 8'h6B);
        chk("b2b err", err[0], 0);
        chk("b2b tx_valid", tx_valid[0], 1);
        step(0, OP_WR_ADDR, 8'h00, 1);

        // Reset while a word is outstanding; memory must survive.
        step(1, OP_RD_ADDR, 8'h20, 0);
        step(1, OP_RD_DATA, 8'h00, 0);
        do_reset("midtx");
        step(1, OP_RD_ADDR, 8'h21, 0);
        step(1, OP_RD_DATA, 8'h00, 0);
        @(negedge clk);
        chk("after reset mem", dout[0], 8'h6B);

        // Every opcode with rx_valid low must do nothing.
        for (int op = 0; op < 4; op++) begin
            for (int k = 0; k < 3; k++) begin
                step(0, 2'(op), 8'($urandom), 0);
            end
        end
        step(0, OP_WR_ADDR, 8'h00, 1);
        step(1, OP_WR_DATA, 8'h99, 0);
        step(1, OP_RD_ADDR, 8'h00, 0);
        step(1, OP_RD_DATA, 8'h00, 1);
        @(negedge clk);
        chk("rxv0 wr_ptr kept", dout[0], 8'h99);

        // Randomized traffic over a small address window.
        for (int n = 0; n < 400; n++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            if (op == OP_WR_ADDR || op == OP_RD_ADDR) begin
                rd_pl = 8'($urandom_range(0, 15));
                if ($urandom_range(0, 9) == 0) rd_pl = 8'hFF;
            end else begin
                rd_pl = 8'($urandom);
            end
            step($urandom_range(0, 3) != 0, op, rd_pl,
                 $urandom_range(0, 1) == 1);
        end

        step(0, OP_WR_ADDR, 8'h00, 1);
        @(negedge clk);
        #1;
        chk("scoreboard drained", sbq0.size() + sbq1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
